updown_sweep_ctrl: RTL and testbench

- Sequencer for the lab's up/down counter datapath. Owns a W-bit count register and its direction control.
- Runs the count in ping-pong sweeps between programmable bounds lo and hi, for a programmed number of sweeps.
- Provides start/busy/done handshake toward a host FSM or test harness.
- Up_Down polarity matches the counter: 1 = count up, 0 = count down.

---
 rtl/updown_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// Ping-pong sweep sequencer for the up/down counter datapath: counts lo->hi->lo for a programmed number of sweeps.
// Optional sticky irq output (with irq_ack input) is enabled by defining SWEEP_CTRL_IRQ_EN.
module updown_sweep_ctrl #(
    parameter int W   = 3,
    parameter int NSW = 4
) (
    input  logic           CP,
    input  logic           CR,
    input  logic           start,
    input  logic           abort,
    input  logic           hold,
    input  logic [W-1:0]   lo,
    input  logic [W-1:0]   hi,
    input  logic [NSW-1:0] sweeps,
`ifdef SWEEP_CTRL_IRQ_EN
    input  logic           irq_ack,
    output logic           irq,
`endif
    output logic [W-1:0]   Q,
    output logic           Up_Down,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [W-1:0]   Q_ONE   = W'(1);
    localparam logic [NSW-1:0] REM_ONE = NSW'(1);

    state_t         state;
    logic [W-1:0]   lo_q;
    logic [W-1:0]   hi_q;
    logic [NSW-1:0] rem;
    logic [W-1:0]   q_inc;
    logic [W-1:0]   q_dec;

    // Q stays inside [lo_q, hi_q] during a run, so these never actually wrap.
    assign q_inc = Q + Q_ONE;
    assign q_dec = Q - Q_ONE;

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state   <= IDLE;
            Q       <= '0;
            Up_Down <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            rem     <= '0;
`ifdef SWEEP_CTRL_IRQ_EN
            irq     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
`ifdef SWEEP_CTRL_IRQ_EN
            // Any set further down this block overrides the acknowledge.
            if (irq_ack) irq <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lo < hi) begin
                            lo_q    <= lo;
                            hi_q    <= hi;
                            rem     <= sweeps;
                            Q       <= lo;
                            state   <= UP;
                            Up_Down <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            err <= 1'b1;
`ifdef SWEEP_CTRL_IRQ_EN
                            irq <= 1'b1;
`endif
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        state   <= IDLE;
                        Up_Down <= 1'b0;
                        busy    <= 1'b0;
                    end else if (!hold) begin
                        Q <= q_inc;
                        if (q_inc == hi_q) begin
                            state   <= DOWN;
                            Up_Down <= 1'b0;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state   <= IDLE;
                        Up_Down <= 1'b0;
                        busy    <= 1'b0;
                    end else if (!hold) begin
                        Q <= q_dec;
                        // Reaching lo closes one sweep; rem==0 means sweep forever.
                        if (q_dec == lo_q) begin
                            if (rem == REM_ONE) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`ifdef SWEEP_CTRL_IRQ_EN
                                irq   <= 1'b1;
`endif
                            end else begin
                                if (rem != '0) rem <= rem - REM_ONE;
                                state   <= UP;
                                Up_Down <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    Up_Down <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Randomized self-checking bench for updown_sweep_ctrl against a trajectory-based reference model.
module tb_updown_sweep_ctrl;

    localparam int W   = 3;
    localparam int NSW = 4;

    logic           CP;
    logic           CR;
    logic           start;
    logic           abort;
    logic           hold;
    logic [W-1:0]   lo_i;
    logic [W-1:0]   hi_i;
    logic [NSW-1:0] sweeps_i;
    logic [W-1:0]   Q;
    logic           Up_Down;
    logic           busy;
    logic           done;
    logic           err;
`ifdef SWEEP_CTRL_IRQ_EN
    logic           irq_ack;
    logic           irq;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_q;

    updown_sweep_ctrl #(.W(W), .NSW(NSW)) dut (
        .CP      (CP),
        .CR      (CR),
        .start   (start),
        .abort   (abort),
        .hold    (hold),
        .lo      (lo_i),
        .hi      (hi_i),
        .sweeps  (sweeps_i),
`ifdef SWEEP_CTRL_IRQ_EN
        .irq_ack (irq_ack),
        .irq     (irq),
`endif
        .Q       (Q),
        .Up_Down (Up_Down),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    // Position p in an endless lo..hi..lo triangle wave.
    function automatic logic [W-1:0] tri_q(input int l, input int h, input int p);
        int period;
        int off;
        period = 2 * (h - l);
        off    = p % period;
        return W'((off <= h - l) ? l + off : l + period - off);
    endfunction

    task automatic test_reset();
        CR = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
        lo_i = '0; hi_i = '0; sweeps_i = '0;
`ifdef SWEEP_CTRL_IRQ_EN
        irq_ack = 1'b0;
`endif
        #12;
        total++;
        if ({Q, busy, Up_Down, done, err} !== {W'(0), 4'b0000}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got Q=%0d busy=%b ud=%b done=%b err=%b, want all 0",
                     Q, busy, Up_Down, done, err);
        end
`ifdef SWEEP_CTRL_IRQ_EN
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_irq: got %b want 0", irq);
        end
`endif
        CR = 1'b1;
        step();
        total++;
        if ({Q, busy, done} !== {W'(0), 2'b00}) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got Q=%0d busy=%b done=%b want 0/0/0", Q, busy, done);
        end
        last_q = '0;
    endtask

    // Runs one programmed job and checks every cycle against the expected trajectory.
    task automatic run_sweep(input logic [W-1:0] l, input logic [W-1:0] h, input logic [NSW-1:0] n,
                             input int hold_pct, input bit noise);
        logic [W-1:0] traj[$];
        int pos;
        int edges;
        int holds;
        int last;
        logic exp_busy;
        logic exp_ud;
        logic exp_done;
        traj = {};
        traj.push_back(l);
        for (int s = 0; s < int'(n); s++) begin
            for (int v = int'(l) + 1; v <= int'(h); v++) traj.push_back(W'(v));
            for (int v = int'(h) - 1; v >= int'(l); v--) traj.push_back(W'(v));
        end
        last = traj.size() - 1;
        lo_i = l; hi_i = h; sweeps_i = n; start = 1'b1; hold = 1'b0;
        step();
        start = 1'b0; abort = 1'b0;
        pos = 0; edges = 1; holds = 0;
        total++;
        if ({Q, busy, Up_Down, done, err} !== {traj[0], 1'b1, 1'b1, 2'b00}) begin
            bad++;
            $display("[TB] FAIL start_accept: got Q=%0d busy=%b ud=%b done=%b err=%b want Q=%0d 1/1/0/0",
                     Q, busy, Up_Down, done, err, traj[0]);
        end
        while (pos < last && edges < 2000) begin
            hold = ($urandom_range(0, 99) < hold_pct);
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                lo_i     = W'($urandom_range(0, 7));
                hi_i     = W'($urandom_range(0, 7));
                sweeps_i = NSW'($urandom_range(0, 15));
            end
            step();
            edges++;
            if (hold) holds++;
            else pos++;
            exp_busy = (pos < last);
            exp_ud   = (pos < last) && (traj[pos + 1] > traj[pos]);
            exp_done = (pos == last);
            total++;
            if ({Q, busy, Up_Down, done, err} !== {traj[pos], exp_busy, exp_ud, exp_done, 1'b0}) begin
                bad++;
                $display("[TB] FAIL sweep_cycle %0d: got Q=%0d busy=%b ud=%b done=%b err=%b want Q=%0d busy=%b ud=%b done=%b err=0",
                         edges, Q, busy, Up_Down, done, err, traj[pos], exp_busy, exp_ud, exp_done);
            end
        end
        total++;
        if (edges != 2 * (int'(h) - int'(l)) * int'(n) + 1 + holds) begin
            bad++;
            $display("[TB] FAIL run_length: got %0d edges want %0d (holds=%0d)",
                     edges, 2 * (int'(h) - int'(l)) * int'(n) + 1 + holds, holds);
        end
        hold = 1'b0; start = 1'b0;
        step();
        total++;
        if ({Q, busy, Up_Down, done} !== {l, 3'b000}) begin
            bad++;
            $display("[TB] FAIL after_done: got Q=%0d busy=%b ud=%b done=%b want Q=%0d 0/0/0",
                     Q, busy, Up_Down, done, l);
        end
        last_q = l;
    endtask

    task automatic test_basic();
        run_sweep(3'd2, 3'd5, 4'd1, 0, 1'b0);
    endtask

    task automatic test_reject();
        logic [W-1:0] bl[2] = '{3'd3, 3'd6};
        logic [W-1:0] bh[2] = '{3'd3, 3'd1};
        for (int i = 0; i < 2; i++) begin
            lo_i = bl[i]; hi_i = bh[i]; sweeps_i = 4'd1; start = 1'b1;
            step();
            start = 1'b0;
            total++;
            if ({Q, busy, done, err} !== {last_q, 3'b001}) begin
                bad++;
                $display("[TB] FAIL reject_%0d: got Q=%0d busy=%b done=%b err=%b want Q=%0d 0/0/1",
                         i, Q, busy, done, err, last_q);
            end
            step();
            total++;
            if ({Q, busy, done, err} !== {last_q, 3'b000}) begin
                bad++;
                $display("[TB] FAIL reject_after_%0d: got Q=%0d busy=%b done=%b err=%b want Q=%0d 0/0/0",
                         i, Q, busy, done, err, last_q);
            end
        end
    endtask

    task automatic test_full_range();
        run_sweep(3'd0, 3'd7, 4'd2, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_sweep(3'd2, 3'd6, 4'd1, 35, 1'b0);
    endtask

    task automatic test_infinite_abort();
        int p;
        lo_i = 3'd1; hi_i = 3'd3; sweeps_i = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        p = 0;
        for (int c = 0; c < 20; c++) begin
            hold = ($urandom_range(0, 99) < 20);
            step();
            if (!hold) p++;
            total++;
            if ({Q, busy, Up_Down, done} !== {tri_q(1, 3, p), 1'b1, tri_q(1, 3, p + 1) > tri_q(1, 3, p), 1'b0}) begin
                bad++;
                $display("[TB] FAIL infinite_cycle %0d: got Q=%0d busy=%b ud=%b done=%b want Q=%0d busy=1 done=0",
                         c, Q, busy, Up_Down, done, tri_q(1, 3, p));
            end
        end
        abort = 1'b1; hold = 1'b1;
        step();
        abort = 1'b0; hold = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({Q, busy, Up_Down, done} !== {tri_q(1, 3, p), 3'b000}) begin
                bad++;
                $display("[TB] FAIL after_abort %0d: got Q=%0d busy=%b ud=%b done=%b want Q=%0d 0/0/0",
                         c, Q, busy, Up_Down, done, tri_q(1, 3, p));
            end
            step();
        end
        last_q = tri_q(1, 3, p);
        // start together with abort in IDLE must still be accepted
        abort = 1'b1;
        run_sweep(3'd1, 3'd3, 4'd1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0]   l;
        logic [W-1:0]   h;
        logic [NSW-1:0] n;
        for (int i = 0; i < 8; i++) begin
            l = W'($urandom_range(0, 6));
            h = W'($urandom_range(int'(l) + 1, 7));
            n = NSW'($urandom_range(1, 3));
            run_sweep(l, h, n, $urandom_range(0, 40), 1'b1);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        lo_i = 3'd2; hi_i = 3'd6; sweeps_i = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (Q !== 3'd4 && guard < 20) begin
            step();
            guard++;
        end
        total++;
        if (Q !== 3'd4) begin
            bad++;
            $display("[TB] FAIL reach_q4: got Q=%0d want 4 within 20 cycles", Q);
        end
        #2 CR = 1'b0;
        #1;
        total++;
        if ({Q, busy, Up_Down} !== {W'(0), 2'b00}) begin
            bad++;
            $display("[TB] FAIL async_clear: got Q=%0d busy=%b ud=%b want 0/0/0", Q, busy, Up_Down);
        end
`ifdef SWEEP_CTRL_IRQ_EN
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_clear_irq: got %b want 0", irq);
        end
`endif
        #1 CR = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if ({Q, busy, done} !== {W'(0), 2'b00}) begin
                bad++;
                $display("[TB] FAIL post_reset %0d: got Q=%0d busy=%b done=%b want 0/0/0", c, Q, busy, done);
            end
        end
        last_q = '0;
    endtask

`ifdef SWEEP_CTRL_IRQ_EN
    task automatic test_irq();
        lo_i = 3'd5; hi_i = 3'd2; start = 1'b1; irq_ack = 1'b0;
        step();
        start = 1'b0;
        step();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL irq_sticky: got %b want 1", irq);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL irq_ack_clear: got %b want 0", irq);
        end
        irq_ack = 1'b1; start = 1'b1;
        step();
        irq_ack = 1'b0; start = 1'b0;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL irq_set_wins: got %b want 1", irq);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        run_sweep(3'd0, 3'd2, 4'd1, 0, 1'b0);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL irq_on_done: got %b want 1", irq);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_full_range();
        test_hold();
        test_infinite_abort();
        test_random();
`ifdef SWEEP_CTRL_IRQ_EN
        test_irq();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
